// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the alu_pipe block.
//   FN_*    : 4-bit operation codes presented on in_func
//   state_t : control FSM states (IDLE, MUL). MUL is used only when the
//             iterative multiplier is built (ALU_PIPE_MUL_EN).
package alu_pkg;

    localparam logic [3:0] FN_AND   = 4'b0000;
    localparam logic [3:0] FN_OR    = 4'b0001;
    localparam logic [3:0] FN_XOR   = 4'b0010;
    localparam logic [3:0] FN_XNOR  = 4'b0011;
    localparam logic [3:0] FN_ADD   = 4'b0100;
    localparam logic [3:0] FN_SLTU  = 4'b0101;
    localparam logic [3:0] FN_SLL   = 4'b0110;
    localparam logic [3:0] FN_SRL   = 4'b0111;
    localparam logic [3:0] FN_ANDN  = 4'b1000;
    localparam logic [3:0] FN_ORN   = 4'b1001;
    localparam logic [3:0] FN_XORN  = 4'b1010;
    localparam logic [3:0] FN_XNORN = 4'b1011;
    localparam logic [3:0] FN_SUB   = 4'b1100;
    localparam logic [3:0] FN_SLT   = 4'b1101;
    localparam logic [3:0] FN_MUL   = 4'b1110;
    localparam logic [3:0] FN_SRA   = 4'b1111;

    typedef enum logic {IDLE, MUL} state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter -- iterative shift-add multiplier, one partial product per
// cycle, WIDTH iterations. Returns the low WIDTH bits of a*b.
//   clk, rst      : clock, synchronous active-high reset (abandons a run)
//   start         : load operands a/b and begin (only when not busy)
//   done          : high during the final iteration cycle; product valid
//   product       : low WIDTH bits of the product, valid while done
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, mcand, mplier, acc_nxt;

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    // Final iteration's sum is presented directly so the caller can
    // register it on the same edge the iteration would have completed.
    assign done    = busy && (cnt == CW'(WIDTH - 1));
    assign product = acc_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;   // wraps back to 0 on the last iteration
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe -- single-issue ALU with valid/ready handshakes and registered
// result + flags. Logic/add/sub/compare/shift ops complete in one cycle.
// Optional macro ALU_PIPE_MUL_EN adds an iterative WIDTH-cycle multiplier
// (func 1110); without it 1110 behaves as an unused code (result 0).
//   clk, rst                   : clock, synchronous active-high reset
//   in_valid/in_ready          : operation handshake
//   in_a, in_b, in_func        : operands, op code (shift amount in in_b low bits)
//   out_valid/out_ready        : result handshake
//   out_result                 : WIDTH-bit result
//   out_zero/neg/carry/ovf     : result flags
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int SW = $clog2(WIDTH);

    logic             accept;
    logic             is_sub;
    logic [WIDTH-1:0] lb, addb, res;
    logic [WIDTH:0]   sum;
    logic             ovf_raw, res_c, res_v;
    logic [SW-1:0]    shamt;

    assign accept = in_valid && in_ready;

    // SUB, SLT and SLTU all share the A + ~B + 1 adder path.
    assign is_sub  = (in_func == FN_SUB) || (in_func == FN_SLT) || (in_func == FN_SLTU);
    assign lb      = in_func[3] ? ~in_b : in_b;
    assign addb    = is_sub ? ~in_b : in_b;
    assign sum     = {1'b0, in_a} + {1'b0, addb} + {{WIDTH{1'b0}}, is_sub};
    assign ovf_raw = (in_a[WIDTH-1] == addb[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
    assign shamt   = in_b[SW-1:0];

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (in_func)
            FN_AND,  FN_ANDN:  res = in_a & lb;
            FN_OR,   FN_ORN:   res = in_a | lb;
            FN_XOR,  FN_XORN:  res = in_a ^ lb;
            FN_XNOR, FN_XNORN: res = ~(in_a ^ lb);
            FN_ADD, FN_SUB: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = ovf_raw;
            end
            // sign of the difference corrected by overflow stays right at extremes
            FN_SLT:  res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_raw};
            FN_SLTU: res = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
            FN_SLL:  res = in_a << shamt;
            FN_SRL:  res = in_a >> shamt;
            FN_SRA:  res = $unsigned($signed(in_a) >>> shamt);
            default: res = '0;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    state_t           state, state_nxt;
    logic             mul_start, mul_done;
    logic [WIDTH-1:0] mul_prod;

    assign mul_start = accept && (in_func == FN_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (in_a),
        .b       (in_b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mul_start) state_nxt = MUL;
            MUL:     if (mul_done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE) && (!out_valid || out_ready);
    end
`else
    assign in_ready = !out_valid || out_ready;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_neg    <= 1'b0;
            out_carry  <= 1'b0;
            out_ovf    <= 1'b0;
        end else begin
`ifdef ALU_PIPE_MUL_EN
            if (mul_done) begin
                out_valid  <= 1'b1;
                out_result <= mul_prod;
                out_zero   <= (mul_prod == '0);
                out_neg    <= mul_prod[WIDTH-1];
                out_carry  <= 1'b0;
                out_ovf    <= 1'b0;
            end else if (mul_start) begin
                // previous result drained this edge; nothing valid until MUL ends
                out_valid <= 1'b0;
            end else
`endif
            if (accept) begin
                out_valid  <= 1'b1;
                out_result <= res;
                out_zero   <= (res == '0);
                out_neg    <= res[WIDTH-1];
                out_carry  <= res_c;
                out_ovf    <= res_v;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0, rst = 1'b1;
    logic         in_valid = 1'b0, in_ready;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic [3:0]   in_func = '0;
    logic         out_valid, out_ready = 1'b0;
    logic [W-1:0] out_result;
    logic         out_zero, out_neg, out_carry, out_ovf;

    int checks = 0, errors = 0;
    bit rand_rdy = 1'b0;

    typedef struct {
        logic [W-1:0] r;
        logic         z, n, c, v;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_func(in_func),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result),
        .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry), .out_ovf(out_ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: straight arithmetic on the operation definitions.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f);
        exp_t   e;
        longint sa, sb, ua, ub, s;
        logic [4:0] sh;
        sa = $signed(a); sb = $signed(b);
        ua = longint'(a); ub = longint'(b);
        sh = b[4:0];
        e.r = '0; e.c = 1'b0; e.v = 1'b0;
        case (f)
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b0010: e.r = a ^ b;
            4'b0011: e.r = ~(a ^ b);
            4'b1000: e.r = a & ~b;
            4'b1001: e.r = a | ~b;
            4'b1010: e.r = a ^ ~b;
            4'b1011: e.r = ~(a ^ ~b);
            4'b0100: begin
                e.r = a + b;
                e.c = (ua + ub) >= 64'h1_0000_0000;
                s   = sa + sb;
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b1100: begin
                e.r = a - b;
                e.c = (a >= b);
                s   = sa - sb;
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b1101: e.r = (sa < sb) ? 32'd1 : 32'd0;
            4'b0101: e.r = (a < b) ? 32'd1 : 32'd0;
            4'b0110: e.r = a << sh;
            4'b0111: e.r = a >> sh;
            4'b1111: e.r = $signed(a) >>> sh;
`ifdef ALU_PIPE_MUL_EN
            4'b1110: e.r = a * b;
`endif
            default: e.r = '0;
        endcase
        e.z = (e.r == '0);
        e.n = e.r[W-1];
        return e;
    endfunction

    // Monitor: every consumed result is popped and compared.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected actual=%0h required=none", out_result);
            end else begin
                e = q.pop_front();
                chk("sb_result", out_result, e.r);
                chk("sb_flags", {out_zero, out_neg, out_carry, out_ovf}, {e.z, e.n, e.c, e.v});
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Call just after a rising edge; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f, output int waits);
        bit ok;
        waits = 0; ok = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_func = f;
        while (!ok && waits <= 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else waits++;
        end
        if (ok) q.push_back(model(a, b, f));
        else begin
            checks++; errors++;
            $display("FAIL issue_timeout actual=no_accept required=accept func=%0h", f);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic flags4(output logic [3:0] fl);
        fl = {out_zero, out_neg, out_carry, out_ovf};
    endtask

    initial begin
        int w, k;
        logic [W-1:0] hold_r;
        logic [3:0]   hold_f, fl;
        logic [3:0]   f;
        logic [W-1:0] ra, rb;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", out_result, 0);
        flags4(fl);
        chk("rst_flags", fl, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        step();

        out_ready = 1'b1;
        issue(32'h7FFF_FFFF, 32'h1, FN_ADD, w);
        chk("add_latency_valid", out_valid, 1);
        chk("add_result", out_result, 32'h8000_0000);
        flags4(fl); chk("add_flags", fl, 4'b0101);

        issue(32'd5, 32'd5, FN_SUB, w);
        chk("sub_result", out_result, 0);
        flags4(fl); chk("sub_flags", fl, 4'b1010);

        issue(32'h8000_0000, 32'h1, FN_SLT, w);
        chk("slt_result", out_result, 1);
        issue(32'h8000_0000, 32'h1, FN_SLTU, w);
        chk("sltu_result", out_result, 0);
        flags4(fl); chk("sltu_flags", fl, 4'b1000);
        issue(32'hF000_0000, 32'd36, FN_SRA, w);
        chk("sra_wrap", out_result, 32'hFF00_0000);
        issue(32'h1, 32'd31, FN_SLL, w);
        chk("sll_31", out_result, 32'h8000_0000);
        issue(32'h1234_5678, 32'd0, FN_SLL, w);
        chk("sll_0", out_result, 32'h1234_5678);

`ifdef ALU_PIPE_MUL_EN
        issue(32'h0001_0001, 32'h0001_0001, FN_MUL, w);
        k = 0;
        while (!out_valid && k < 40) begin
            chk("mul_in_ready", in_ready, 0);
            step();
            k++;
        end
        chk("mul_latency", k, 32);
        chk("mul_result", out_result, 32'h0002_0001);
`else
        issue(32'h0001_0001, 32'h0001_0001, 4'b1110, w);
        chk("unused_1110_valid", out_valid, 1);
        chk("unused_1110_result", out_result, 0);
        flags4(fl); chk("unused_1110_flags", fl, 4'b1000);
`endif

        // Stall: result and flags hold while the consumer is not ready.
        step();
        out_ready = 1'b0;
        issue($urandom, $urandom, FN_AND, w);
        hold_r = out_result;
        flags4(hold_f);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", out_valid, 1);
            chk("stall_result", out_result, hold_r);
            flags4(fl); chk("stall_flags", fl, hold_f);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            f = 4'($urandom_range(0, 15));
            if (f == FN_MUL) f = FN_ADD;
            issue($urandom, $urandom, f, w);
            chk("b2b_wait", w, 0);
            chk("b2b_valid", out_valid, 1);
        end

`ifdef ALU_PIPE_MUL_EN
        // Reset part way through a multiply: no result may appear.
        step();
        issue($urandom | 32'h1, $urandom | 32'h1, FN_MUL, w);
        repeat (9) step();
        rst = 1'b1;
        q.delete();
        step();
        rst = 1'b0;
        chk("mulrst_in_ready", in_ready, 1);
        for (int i = 0; i < 40; i++) begin
            chk("mulrst_valid", out_valid, 0);
            chk("mulrst_result", out_result, 0);
            step();
        end
        issue(32'd3, 32'd4, FN_ADD, w);
        chk("mulrst_next_wait", w, 0);
        chk("mulrst_next_result", out_result, 7);
`endif

        // Randomized traffic with random back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            f  = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: rb = 32'h7FFF_FFFF;
                2: rb = ra;
                3: rb = 32'($urandom_range(0, 70));
                default: ;
            endcase
            issue(ra, rb, f, w);
        end
        rand_rdy = 1'b0;
        step();
        out_ready = 1'b1;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            step();
            k++;
        end
        step();
        chk("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; SHALL be a power of two, 8..64.
REQ-002 Port: clk  input  1  clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: in_valid  input  1  operation offered this cycle.
REQ-005 Port: in_ready  output  1  block accepts offered operation this cycle.
REQ-006 Port: in_a  input  WIDTH  operand A.
REQ-007 Port: in_b  input  WIDTH  operand B; shift amount = in_b[log2(WIDTH)-1:0].
REQ-008 Port: in_func  input  4  operation code (REQ-012).
REQ-009 Port: out_valid  output  1  result registers hold an unconsumed result.
REQ-010 Port: out_ready  input  1  consumer takes result this cycle.
REQ-011 Port: out_result  output  WIDTH  result; out_zero, out_neg, out_carry, out_ovf  output  1 each  flags.

Function
REQ-012 Encoding SHALL be: 0000 AND, 0001 OR, 0010 XOR, 0011 XNOR, 1000-1011 same four ops with ~B, 0100 ADD, 1100 SUB (A+~B+1), 1101 SLT signed, 0101 SLTU, 0110 SLL, 0111 SRL, 1111 SRA, 1110 MUL; all other codes give result 0.
REQ-013 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-014 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready), combinationally.
REQ-015 Non-MUL ops SHALL have latency 1: result and flags registered on the accepting edge; out_valid set that edge.
REQ-016 SLT SHALL use sum sign XOR signed overflow (correct at extremes); SLTU SHALL use !carry of A+~B+1; both give {WIDTH-1 zeros, bit}.
REQ-017 out_carry SHALL be the carry out of the WIDTH-bit adder for ADD/SUB, else 0; out_ovf SHALL be two's-complement overflow for ADD/SUB, else 0.
REQ-018 out_zero SHALL be (out_result==0); out_neg SHALL be out_result[WIDTH-1]; both for every op.
REQ-019 FSM states IDLE, MUL: IDLE->MUL on accepted MUL; MUL->IDLE after exactly WIDTH iteration cycles, loading low WIDTH bits of product and setting out_valid on that edge.
REQ-020 While in MUL, in_ready SHALL be 0; a pending result SHALL still drain when out_ready is high.
REQ-021 Output registers SHALL hold stable while out_valid && !out_ready.
REQ-022 Simultaneous drain and accept SHALL overwrite the result with the new op (non-MUL) with out_valid staying 1; for MUL, out_valid SHALL drop to 0 until MUL completes.
REQ-023 Shift amounts SHALL wrap modulo WIDTH; SLL by 0 returns A unchanged.

Reset
REQ-024 rst SHALL force state IDLE, iteration counter 0, out_valid 0, out_result 0, all flags 0, overriding any other event that cycle.
REQ-025 rst during MUL SHALL abandon the operation; no result SHALL emerge; in_ready SHALL be 1 the cycle after rst deasserts.

Configuration
REQ-026 Macro ALU_PIPE_MUL_EN defined: MUL per REQ-019.
REQ-027 Macro undefined: code 1110 SHALL behave as an unused code (latency 1, result 0, out_zero 1); MUL state and iteration logic SHALL not exist.

Structure
REQ-028 Package alu_pkg SHALL hold the 4-bit func localparams and the state enum typedef.
REQ-029 Iterative shift-add multiplier SHALL be sub-module alu_mul_iter (start, done, WIDTH-cycle count), instantiated only under ALU_PIPE_MUL_EN.

Verification
REQ-030 WIDTH=32, ADD 0x7FFFFFFF+1 -> result 0x80000000, ovf 1, carry 0, neg 1, out_valid one cycle after accept.
REQ-031 SUB 5-5 -> 0, zero 1, carry 1; SLT 0x80000000 vs 1 -> 1; SLTU same operands -> 0.
REQ-032 SRA 0xF0000000 by 36 -> 0xFF000000 (wraps to 4); SLL 1 by 31 -> 0x80000000.
REQ-033 MUL_EN: MUL 0x10001 x 0x10001 -> 0x00020001 exactly 32 cycles after accept; in_ready 0 throughout.
REQ-034 out_ready held 0 for 5 cycles after AND result -> result/flags stable, in_ready 0; then back-to-back ops with out_ready 1 -> one result per cycle.
REQ-035 rst asserted mid-MUL (cycle 10) -> out_valid stays 0, out_result 0, next op accepted normally.
